// File: rtl/unidade_controle_jogo_pkg.sv
// Shared types for the game control unit: state codes and output bundle.
// The state codes double as the db_estado display value.
package unidade_controle_jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARA     = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARA     = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTO  = 4'b1010,
    FIM_ERRO    = 4'b1110,
    FIM_TIMEOUT = 4'b1101
  } estado_t;

  typedef struct packed {
    logic zeraC;
    logic contaC;
    logic zeraR;
    logic registraR;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  function automatic saidas_t decodifica(
    estado_t e
  );
    saidas_t s;
    s = '0;
    case (e)
      PREPARA: begin
        s.zeraC = 1'b1;
        s.zeraR = 1'b1;
      end
      REGISTRA: s.registraR = 1'b1;
      PROXIMO:  s.contaC = 1'b1;
      FIM_ACERTO: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_ERRO: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game controller and its datapath.
// master: controller side; slave: datapath / environment side.
interface unidade_controle_jogo_if;
  logic       iniciar;
  logic       fimC;
  logic       jogada_feita;
  logic       igual;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, fimC, jogada_feita, igual,
    output zeraC, contaC, zeraR, registraR,
    output pronto, acertou, errou, timeout,
    output db_estado
  );

  modport slave (
    output iniciar, fimC, jogada_feita, igual,
    input  zeraC, contaC, zeraR, registraR,
    input  pronto, acertou, errou, timeout,
    input  db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Saturating play-wait timer: clr, en, count; fim on the last allowed cycle.
// Ports: clock, reset (async high), clr, en, fim. LIMITE=0 disables fim.
module contador_timeout #(
  parameter int LIMITE = 3000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic fim
);

  localparam int W =
    (LIMITE < 1) ? 1 : $clog2(LIMITE + 1);
  localparam logic [W-1:0] MAXV = W'(LIMITE);
  localparam logic [W-1:0] FIMV =
    (LIMITE > 0) ? W'(LIMITE - 1) : '0;

  logic [W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != MAXV) begin
      cnt <= cnt + W'(1);
    end
  end

  // fim fires on the LIMITE-th waiting cycle
  assign fim = (LIMITE > 0) && en
            && (cnt == FIMV);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore FSM sequencing one game round over the datapath.
// Ports: clock, reset (async high), bus (master modport of the control bundle).
module unidade_controle_jogo
  import unidade_controle_jogo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 3000
) (
  input logic                     clock,
  input logic                     reset,
  unidade_controle_jogo_if.master bus
);

  estado_t estado;
  estado_t proximo;
  saidas_t saidas;
  logic    timer_fim;
  logic    timer_clr;
  logic    timer_en;

  assign timer_clr = (estado == PREPARA)
                  || (estado == PROXIMO);
  assign timer_en  = (estado == ESPERA);

  contador_timeout #(
    .LIMITE (TIMEOUT_CICLOS)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .fim   (timer_fim)
  );

  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:
        proximo = bus.iniciar ? PREPARA : INICIAL;
      PREPARA:
        proximo = ESPERA;
      ESPERA: begin
        // a play on the last allowed cycle still counts
        if (bus.jogada_feita)
          proximo = REGISTRA;
        else if (timer_fim)
          proximo = FIM_TIMEOUT;
        else
          proximo = ESPERA;
      end
      REGISTRA:
        proximo = COMPARA;
      COMPARA: begin
        if (!bus.igual)
          proximo = FIM_ERRO;
        else if (bus.fimC)
          proximo = FIM_ACERTO;
        else
          proximo = PROXIMO;
      end
      PROXIMO:
        proximo = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
        proximo = bus.iniciar ? PREPARA : estado;
      default:
        proximo = INICIAL;
    endcase
  end

  // outputs registered from the next state so they track estado exactly
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= INICIAL;
      saidas <= '0;
    end else begin
      estado <= proximo;
      saidas <= decodifica(proximo);
    end
  end

  assign bus.zeraC     = saidas.zeraC;
  assign bus.contaC    = saidas.contaC;
  assign bus.zeraR     = saidas.zeraR;
  assign bus.registraR = saidas.registraR;
  assign bus.pronto    = saidas.pronto;
  assign bus.acertou   = saidas.acertou;
  assign bus.errou     = saidas.errou;
  assign bus.timeout   = saidas.timeout;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Scoreboard bench for unidade_controle_jogo (TIMEOUT_CICLOS=10).
// Stimulus pushes expected round results; a monitor checks them on pronto.
module tb_unidade_controle_jogo;
  import unidade_controle_jogo_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  unidade_controle_jogo_if bus ();

  unidade_controle_jogo #(
    .TIMEOUT_CICLOS (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] estado;
    logic [2:0] flags;
    int         nconta;
    int         nreg;
    int         nesp;
  } res_t;

  res_t fila[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(
    input string       nome,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nome, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.zeraC, bus.contaC,
            bus.zeraR, bus.registraR,
            bus.pronto, bus.acertou,
            bus.errou, bus.timeout};
  endfunction

  // monitor: per-round activity counters, verdict on pronto rise
  int   nconta;
  int   nreg;
  int   nesp;
  logic prev_pronto = 1'b0;
  res_t r;

  always @(negedge clock) begin
    if (reset) begin
      nconta = 0;
      nreg = 0;
      nesp = 0;
      prev_pronto = 1'b0;
    end else begin
      if (bus.db_estado == PREPARA) begin
        nconta = 0;
        nreg = 0;
        nesp = 0;
      end else begin
        nconta += int'(bus.contaC);
        nreg += int'(bus.registraR);
        if (bus.db_estado == ESPERA) nesp++;
      end
      if (bus.pronto && !prev_pronto) begin
        if (fila.size() == 0) begin
          check("fila_vazia", fila.size(), 1);
        end else begin
          r = fila.pop_front();
          check("estado", bus.db_estado, r.estado);
          check("flags",
                {bus.acertou, bus.errou, bus.timeout},
                r.flags);
          check("nconta", nconta, r.nconta);
          check("nreg", nreg, r.nreg);
          check("nesp", nesp, r.nesp);
        end
      end
      prev_pronto = bus.pronto;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_estado(
    input logic [3:0] e,
    input int         limite
  );
    int n = 0;
    while (bus.db_estado !== e && n < limite) begin
      tick();
      n++;
    end
    if (bus.db_estado !== e)
      check("espera_estado", bus.db_estado, e);
  endtask

  task automatic wait_pronto(input int limite);
    int n = 0;
    while (bus.pronto !== 1'b1 && n < limite) begin
      tick();
      n++;
    end
    if (bus.pronto !== 1'b1)
      check("espera_pronto", bus.pronto, 1);
  endtask

  // play pulse on the k-th ESPERA cycle
  task automatic jogar(
    input int   k,
    input logic ig,
    input logic fc
  );
    wait_estado(ESPERA, 40);
    repeat (k - 1) tick();
    bus.jogada_feita = 1'b1;
    bus.igual = ig;
    bus.fimC = fc;
    tick();
    bus.jogada_feita = 1'b0;
    check("registra", bus.db_estado, REGISTRA);
  endtask

  task automatic iniciar_rodada();
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    bus.iniciar = 1'b0;
    bus.fimC = 1'b0;
    bus.jogada_feita = 1'b0;
    bus.igual = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_estado", bus.db_estado, 4'b0000);
    check("rst_saidas", outs(), 8'h00);
    reset = 1'b0;
    tick();

    // abort in COMPARA with async reset
    iniciar_rodada();
    jogar(1, 1'b1, 1'b0);
    tick();
    check("compara", bus.db_estado, 4'b0101);
    #2;
    reset = 1'b1;
    #1;
    check("abort_estado", bus.db_estado, 4'b0000);
    check("abort_saidas", outs(), 8'h00);
    tick();
    reset = 1'b0;
    tick();

    // full hit: 16 plays
    fila.push_back('{4'b1010, 3'b100, 15, 16, 16});
    iniciar_rodada();
    for (int i = 0; i < 16; i++)
      jogar(1, 1'b1, (i == 15));
    wait_pronto(10);
    bus.jogada_feita = 1'b1;
    tick();
    bus.jogada_feita = 1'b0;
    tick();
    check("hold_acerto", bus.db_estado, 4'b1010);
    check("hold_saidas", outs(), 8'b0000_1100);

    // miss on 3rd play
    fila.push_back('{4'b1110, 3'b010, 2, 3, 3});
    iniciar_rodada();
    bus.fimC = 1'b0;
    jogar(1, 1'b1, 1'b0);
    jogar(1, 1'b1, 1'b0);
    jogar(1, 1'b0, 1'b0);
    wait_pronto(10);
    tick();

    // iniciar held in FIM_ERRO, then pure timeout
    fila.push_back('{4'b1101, 3'b001, 0, 0, 10});
    bus.iniciar = 1'b1;
    tick();
    check("rest_estado", bus.db_estado, 4'b0001);
    check("rest_saidas", outs(), 8'b1010_0000);
    bus.iniciar = 1'b0;
    wait_pronto(30);
    tick();
    check("hold_timeout", outs(), 8'b0000_1001);

    // plays on the last allowed cycle, then timeout
    fila.push_back('{4'b1101, 3'b001, 2, 2, 30});
    iniciar_rodada();
    jogar(10, 1'b1, 1'b0);
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    jogar(10, 1'b1, 1'b0);
    wait_pronto(40);
    tick();
    tick();

    check("fila_final", fila.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
